// File: rtl/fetch_seq_if.sv
// ---------------------------------------------------------------------------
// fetch_seq_if
//   Bundles the fetch sequencer's memory-side and control-side signals.
//
//   Memory side : imem_req/imem_addr (out), imem_ack/imem_rdata (in)
//   Ctrl side   : ir/ir_valid (out), ir_ready, br_taken, br_addr, halt (in)
//   Status      : pc, busy, fault (out)
//
//   modport master : the fetch sequencer
//   modport slave  : memory + control unit
// ---------------------------------------------------------------------------
interface fetch_seq_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     ir;
  logic            ir_valid;
  logic            ir_ready;
  logic            br_taken;
  logic [PC_W-1:0] br_addr;
  logic            halt;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            fault;

  modport master (
    output imem_req, imem_addr, ir, ir_valid, pc, busy, fault,
    input  imem_ack, imem_rdata, ir_ready, br_taken, br_addr, halt
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid, pc, busy, fault,
    output imem_ack, imem_rdata, ir_ready, br_taken, br_addr, halt
  );
endinterface

// File: rtl/fetch_seq.sv
// ---------------------------------------------------------------------------
// fetch_seq
//   Instruction-fetch sequencer. Owns the PC, fetches one word at a time over
//   a req/ack handshake, holds it in the instruction register until the
//   control unit consumes it, then applies an optional branch redirect and
//   either refetches or halts. A request left unacknowledged too long puts
//   the block into a sticky FAULT state.
//
//   Ports:
//     clk    : clock, all state changes on rising edge
//     rst_f  : synchronous active-high reset
//     bus    : fetch_seq_if.master (memory handshake, ir handshake, status)
//
//   Parameters:
//     PC_W     : PC / address width
//     RESET_PC : PC loaded on reset
//     TIMEOUT  : wait-counter value at which an unacked request faults
// ---------------------------------------------------------------------------
module fetch_seq #(
  parameter int          PC_W     = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  fetch_seq_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_HOLD   = 3'd2,
    S_HALTED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [7:0]      TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [PC_W-1:0] RESET_PC_C = PC_W'(RESET_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            fault_q, fault_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;

  logic            consume;

  // ir_valid_q is only ever set in HOLD, so this is the consume cycle.
  assign consume = ir_valid_q & bus.ir_ready;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC_C;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        wait_cnt_d = 8'd0;
        state_d    = S_REQ;
      end

      S_REQ: begin
        // An ack arriving on the timeout cycle still wins over the fault.
        if (bus.imem_ack) begin
          ir_d       = bus.imem_rdata;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = S_HOLD;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (consume) begin
          ir_valid_d = 1'b0;
          if (bus.br_taken) begin
            pc_d = bus.br_addr;
          end
          // Halt wins over refetch, but a simultaneous branch still lands.
          state_d = bus.halt ? S_HALTED : S_REQ;
        end
      end

      S_HALTED: begin
        ir_valid_d = 1'b0;
      end

      S_FAULT: begin
        ir_valid_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req  = (state_q == S_REQ);
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.pc        = pc_q;
  assign bus.busy      = (state_q == S_REQ) || (state_q == S_HOLD);
  assign bus.fault     = fault_q;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch sequencer for the SISC processor.
- Owns the program counter and drives a request/acknowledge handshake to instruction memory.
- Latches each returned word into the instruction register and presents it to the control unit with a valid/ready handshake.
- Applies branch redirects from the control unit and supports halt and fetch-timeout fault.

Parameters:
PC_W, 16, program counter and instruction address width in bits
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, max cycles a memory request may stay unacknowledged before fault (1..255)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_f  input  1  reset, synchronous, active-high
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_W  fetch address, equals pc while imem_req high
imem_ack  input  1  memory acknowledge; imem_rdata valid in same cycle
imem_rdata  input  32  instruction word from memory
ir  output  32  instruction register to ctrl/rf/alu
ir_valid  output  1  ir holds an unconsumed instruction
ir_ready  input  1  ctrl accepts ir this cycle
br_taken  input  1  redirect PC; sampled only in consume cycle
br_addr  input  PC_W  branch target
halt  input  1  stop fetching after current instruction is consumed
pc  output  PC_W  current program counter (address of next fetch)
busy  output  1  high in REQ or HOLD
fault  output  1  sticky fetch-timeout flag

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_f` is synchronous and active-high, sampled on the rising edge.
- Reset values (dominates all other inputs, including in mid-request):
  - pc = RESET_PC, ir = 32'h0, ir_valid = 0, imem_req = 0, fault = 0, wait counter = 0, state = IDLE.
  - An outstanding request is abandoned. An imem_ack arriving in the reset cycle is ignored.
- States: IDLE, REQ, HOLD, HALTED, FAULT.
- IDLE:
  - Entered from reset.
  - Next cycle unconditionally -> REQ.
  - busy = 0.
- REQ:
  - imem_req = 1 and imem_addr = pc, both stable every cycle until ack.
  - On imem_ack:
    - ir <= imem_rdata, ir_valid <= 1, pc <= pc + 1 (mod 2^PC_W, so all-ones wraps to 0).
    - Wait counter cleared, -> HOLD.
    - imem_req drops in the following cycle.
  - Without ack: wait counter increments.
  - When wait counter == TIMEOUT with no ack, all in the same edge: fault <= 1, imem_req <= 0, -> FAULT.
  - Ack in the same cycle the counter reaches TIMEOUT counts as success; no fault.
- HOLD:
  - imem_req = 0, ir_valid = 1, ir stable.
  - Consume when ir_valid & ir_ready; ir_valid <= 0 on consume.
  - If br_taken in the consume cycle: pc <= br_addr. br_taken and br_addr are ignored in every other cycle.
  - If halt in the consume cycle -> HALTED. Halt takes priority over refetch; a simultaneous br_taken still updates pc.
  - Otherwise -> REQ.
  - While not consumed, remain in HOLD indefinitely.
- Latency:
  - Ack in cycle N -> ir_valid high in N+1.
  - Consume in cycle M -> imem_req high in M+1.
  - Peak throughput: one instruction per 2 cycles.
- HALTED:
  - imem_req = 0, ir_valid = 0, busy = 0, pc holds.
  - Exit only by reset.
- FAULT:
  - fault = 1, imem_req = 0, ir_valid = 0, busy = 0.
  - Exit only by reset.
- Spurious inputs:
  - imem_ack outside REQ is ignored.
  - ir_ready with ir_valid = 0 is ignored.
  - halt outside the consume cycle is ignored.
- pc output: always reflects the address of the next fetch, registered.

Test Plan:
1. Reset with RESET_PC = 16'h0000, then ack each request after 1 cycle with rdata = 32'h10000001, 32'h20000002, ir_ready tied high -> imem_addr sequence 0, 1; ir presents each word one cycle after its ack; pc = 2 after second consume.
2. Ack 3 cycles after req; ir_ready held low for 4 cycles after ir_valid -> imem_req and imem_addr stable through the wait; ir and ir_valid stable until ready; exactly one pc increment.
3. Consume with br_taken = 1, br_addr = 16'h0040 -> next imem_addr = 16'h0040. br_taken pulsed while in REQ -> no effect on pc.
4. PC wrap: RESET_PC = 16'hFFFF, ack -> pc = 16'h0000 and next imem_addr = 0.
5. Timeout: TIMEOUT = 15, no ack -> fault = 1 on edge 15 after req rises, req low, stays in FAULT. Ack on cycle 15 instead -> no fault, ir loaded.
6. halt with consume -> HALTED, no further req. rst_f asserted mid-REQ with simultaneous ack -> ir = 0, ir_valid = 0, pc = RESET_PC; refetch starts 2 cycles after reset release.
